router_1x3_top: RTL and testbench
=================================

# router_1x3_top

Packet router with one 8-bit byte-serial ingress port and three egress ports. Each packet has a header byte, then payload bytes, then a parity byte. The header steers the packet into one of three 16-entry output FIFOs, and the block back-pressures the source with `busy`. The block is the top of the router subsystem: the upstream packet source drives it, and three independent downstream readers drain it.

## Interface
- No parameters. Depth, width and address codes are package constants.
- `clock` in 1: rising-edge clock.
- `resetn` in 1: asynchronous reset, **active-high** (1 = reset). The name is kept from the codebase.
- `pkt_valid` in 1: high while header and payload bytes are driven. Low on the parity byte.
- `data_in` in 8: ingress byte.
- `read_enb_0/1/2` in 1: per-port read request.
- `data_out_0/1/2` out 8: per-port egress byte (registered).
- `valid_out_0/1/2` out 1: the port's FIFO is non-empty.
- `busy` out 1: the ingress cannot accept a byte this cycle.
- `error` out 1: parity mismatch on the last completed packet.

## Operation
- **Packet format**
  - Header byte = {len[5:0], addr[1:0]}. `len` is informational only; packet end is marked by `pkt_valid` falling.
  - Valid addresses are 0, 1 and 2. Address 3 is invalid.
  - Parity byte = XOR of the header and all payload bytes.
- **Accept rule:** a byte is consumed at a rising edge only when `busy`=0 at that edge. The source holds `data_in`/`pkt_valid` while `busy`=1.
- **FSM states:** DECODE, WAIT_EMPTY, LOAD_DATA, CHECK, DROP.
- **DECODE** (`busy`=0). At an edge with `pkt_valid`=1:
  - addr=3: go to DROP.
  - Target FIFO empty: write the header into it, clear `error`, init parity = header, latch addr, go to LOAD_DATA.
  - Target FIFO non-empty: latch the header in a hold register, go to WAIT_EMPTY.
  - `pkt_valid`=0: ignore the input.
- **WAIT_EMPTY** (`busy`=1). When the target FIFO is empty, write the held header, clear `error`, init parity, go to LOAD_DATA.
- **LOAD_DATA** (`busy` = target FIFO full). At an accepting edge:
  - `pkt_valid`=1: write `data_in` and XOR it into parity.
  - `pkt_valid`=0: write `data_in` as the parity byte, register the mismatch flag, go to CHECK.
- **CHECK** (`busy`=1, one cycle). `error` <= mismatch flag, then go to DECODE.
- **DROP** (`busy`=0). Discard bytes while `pkt_valid`=1. Go to DECODE on the first edge with `pkt_valid`=0; that parity byte is discarded too.
- `error` holds its value until the next header write.
- **FIFO (per port)**
  - 16 entries × 8 bits, occupancy count 0–16.
  - Full = 16, empty = 0, `valid_out` = !empty.
  - Simultaneous write and read: both happen, the count is unchanged.
  - Read while empty: ignored, `data_out` holds.
  - Write while full: never occurs, because `busy` blocks it.
- Only one FIFO is written per cycle. All three FIFOs read independently.

## Timing
- **Reset (asynchronous):**
  - FSM goes to DECODE.
  - All FIFOs empty, pointers and counts 0.
  - `data_out_*`=0, `valid_out_*`=0, `busy`=0, `error`=0.
  - Hold and parity registers are 0.
  - Reset mid-packet discards all stored data, including the partial packet.
- **Write to valid:** a byte written at edge N makes `valid_out` high after edge N.
- **Read latency:** with `read_enb` high and the FIFO non-empty at edge N, `data_out` shows the oldest byte after edge N and the count decrements. `valid_out` falls after the edge that reads the last byte.
- `busy` is combinational from state and FIFO full.
- **16-byte boundary:** with no reads, after the 16th byte is written (header + 15 payload) `busy`=1. The first read deasserts `busy` in the next cycle.
- **Pointer arithmetic:** 4-bit pointers wrap 15→0.

## Structure
- Package `router_pkg`:
  - FIFO_DEPTH=16, DATA_W=8.
  - ADDR_INVALID=2'b11.
  - FSM state enum.
- Sub-module `router_fifo`, 16×8 synchronous FIFO with count, instantiated three times.
- The top holds the FSM, the hold register, the parity accumulator, and the write and valid demux.

## Test plan
- **Reset:** assert `resetn`=1 mid-packet, release → all outputs 0, `busy`=0, all `valid_out`=0.
- **Normal packet:** header 0x3A (len 14, addr 2), 14 random payload bytes, correct parity; no read until `pkt_valid` falls, then `read_enb_2`=1 until `valid_out_2`=0 → exactly 16 bytes out in order starting 0x3A, `error`=0. Ports 0 and 1 stay invalid.
- **Parity error:** same packet with the parity byte XOR 0x01 → `error`=1 one cycle after the parity byte is accepted. `error` clears when the next header is written.
- **Back-pressure:** len 18 to addr 2, no reads → `busy`=1 after 16 bytes. Enable `read_enb_2` → packet completes and 20 bytes are read in order, `error`=0.
- **Invalid address:** header addr=3 with 5 payload bytes and parity → no `valid_out`, `busy` stays 0. The next valid packet routes normally.
- **Same-port back-to-back:** second header to addr 0 while FIFO 0 is non-empty → `busy`=1 until FIFO 0 is drained, then the header is written and loading resumes.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and FSM encoding for the 1x3 packet router.
package router_pkg;
   localparam int FIFO_DEPTH = 16;
   localparam int DATA_W = 8;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE,
      WAIT_EMPTY,
      LOAD_DATA,
      CHECK,
      DROP
   } state_t;
endpackage

// File: rtl/router_fifo.sv
// 16x8 synchronous FIFO with occupancy count and registered read data.
module router_fifo
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic              do_wr;
   logic              do_rd;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Storage kept free of reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (do_wr)
         mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         dout       <= '0;
      end else begin
         if (do_wr)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            dout       <= mem[rd_ptr_reg];
         end
         case ({do_wr, do_rd})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/router_1x3_top.sv
// Byte-serial packet router: header steers each packet into one of three FIFOs,
// with parity checking and back-pressure on the source.
module router_1x3_top
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_enb_0,
   input  logic              read_enb_1,
   input  logic              read_enb_2,
   output logic [DATA_W-1:0] data_out_0,
   output logic [DATA_W-1:0] data_out_1,
   output logic [DATA_W-1:0] data_out_2,
   output logic              valid_out_0,
   output logic              valid_out_1,
   output logic              valid_out_2,
   output logic              busy,
   output logic              error
);
   state_t            state_reg;
   logic [1:0]        addr_reg;
   logic [DATA_W-1:0] hold_reg;
   logic [DATA_W-1:0] parity_reg;
   logic              mismatch_reg;
   logic              error_reg;

   logic [2:0]        empty_w;
   logic [2:0]        full_w;
   logic [2:0]        rd_en_w;
   logic [2:0]        wr_en_w;
   logic [3:0]        empty_vec;
   logic [3:0]        full_vec;
   logic [DATA_W-1:0] dout_w [3];
   logic [DATA_W-1:0] wr_data;
   logic              wr_req;
   logic [1:0]        wr_port;
   logic [1:0]        hdr_addr;

   // Bit 3 pads the invalid address so any 2-bit address indexes safely.
   assign empty_vec = {1'b1, empty_w};
   assign full_vec  = {1'b0, full_w};
   assign hdr_addr  = data_in[1:0];
   assign rd_en_w   = {read_enb_2, read_enb_1, read_enb_0};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_port
         router_fifo u_fifo (
            .clock (clock),
            .rst   (resetn),
            .wr_en (wr_en_w[gi]),
            .din   (wr_data),
            .rd_en (rd_en_w[gi]),
            .dout  (dout_w[gi]),
            .empty (empty_w[gi]),
            .full  (full_w[gi])
         );
      end
   endgenerate

   always_comb begin
      wr_req  = 1'b0;
      wr_port = addr_reg;
      wr_data = data_in;
      case (state_reg)
         DECODE: begin
            if (pkt_valid && hdr_addr != ADDR_INVALID && empty_vec[hdr_addr]) begin
               wr_req  = 1'b1;
               wr_port = hdr_addr;
            end
         end
         WAIT_EMPTY: begin
            if (empty_vec[addr_reg]) begin
               wr_req  = 1'b1;
               wr_data = hold_reg;
            end
         end
         LOAD_DATA: wr_req = !full_vec[addr_reg];
         default:   wr_req = 1'b0;
      endcase
      wr_en_w = {3{wr_req}} & (3'b001 << wr_port);
   end

   always_comb begin
      case (state_reg)
         WAIT_EMPTY, CHECK: busy = 1'b1;
         LOAD_DATA:         busy = full_vec[addr_reg];
         default:           busy = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state_reg    <= DECODE;
         addr_reg     <= '0;
         hold_reg     <= '0;
         parity_reg   <= '0;
         mismatch_reg <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         case (state_reg)
            DECODE: begin
               if (pkt_valid) begin
                  if (hdr_addr == ADDR_INVALID) begin
                     state_reg <= DROP;
                  end else begin
                     addr_reg <= hdr_addr;
                     if (empty_vec[hdr_addr]) begin
                        parity_reg <= data_in;
                        error_reg  <= 1'b0;
                        state_reg  <= LOAD_DATA;
                     end else begin
                        hold_reg  <= data_in;
                        state_reg <= WAIT_EMPTY;
                     end
                  end
               end
            end
            WAIT_EMPTY: begin
               if (empty_vec[addr_reg]) begin
                  parity_reg <= hold_reg;
                  error_reg  <= 1'b0;
                  state_reg  <= LOAD_DATA;
               end
            end
            LOAD_DATA: begin
               // The byte arriving with pkt_valid low is the parity byte itself.
               if (!full_vec[addr_reg]) begin
                  if (pkt_valid) begin
                     parity_reg <= parity_reg ^ data_in;
                  end else begin
                     mismatch_reg <= (parity_reg != data_in);
                     state_reg    <= CHECK;
                  end
               end
            end
            CHECK: begin
               error_reg <= mismatch_reg;
               state_reg <= DECODE;
            end
            DROP: begin
               if (!pkt_valid)
                  state_reg <= DECODE;
            end
            default: state_reg <= DECODE;
         endcase
      end
   end

   assign error       = error_reg;
   assign data_out_0  = dout_w[0];
   assign data_out_1  = dout_w[1];
   assign data_out_2  = dout_w[2];
   assign valid_out_0 = !empty_w[0];
   assign valid_out_1 = !empty_w[1];
   assign valid_out_2 = !empty_w[2];
endmodule

// File: tb/tb_router_1x3_top.sv
// Directed bench for router_1x3_top: per-cycle vector table plus packet-level sequences.
module tb_router_1x3_top;
   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic [7:0] data_out_0, data_out_1, data_out_2;
   logic       valid_out_0, valid_out_1, valid_out_2;
   logic       busy;
   logic       error;

   int errors = 0;
   int checks = 0;

   logic [7:0] q0[$], q1[$], q2[$];
   logic [7:0] exp_q[$];
   logic [7:0] pl[$];
   logic       fire0 = 1'b0, fire1 = 1'b0, fire2 = 1'b0;

   typedef struct {
      logic       pv;
      logic [7:0] din;
      logic       rd1;
      logic       exp_busy;
      logic       exp_v1;
      logic [7:0] exp_dout1;
      logic       exp_err;
   } vec_t;
   vec_t vt[9];

   router_1x3_top dut (
      .clock       (clock),
      .resetn      (resetn),
      .pkt_valid   (pkt_valid),
      .data_in     (data_in),
      .read_enb_0  (read_enb_0),
      .read_enb_1  (read_enb_1),
      .read_enb_2  (read_enb_2),
      .data_out_0  (data_out_0),
      .data_out_1  (data_out_1),
      .data_out_2  (data_out_2),
      .valid_out_0 (valid_out_0),
      .valid_out_1 (valid_out_1),
      .valid_out_2 (valid_out_2),
      .busy        (busy),
      .error       (error)
   );

   always #5 clock = ~clock;

   // A read fires at an edge where enable and valid are both high; the byte is visible after it.
   always @(posedge clock) begin
      fire0 <= read_enb_0 && valid_out_0;
      fire1 <= read_enb_1 && valid_out_1;
      fire2 <= read_enb_2 && valid_out_2;
   end

   always @(negedge clock) begin
      if (fire0) q0.push_back(data_out_0);
      if (fire1) q1.push_back(data_out_1);
      if (fire2) q2.push_back(data_out_2);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic vld(input int p);
      case (p)
         0:       return valid_out_0;
         1:       return valid_out_1;
         default: return valid_out_2;
      endcase
   endfunction

   task automatic set_rd(input int p, input logic v);
      case (p)
         0:       read_enb_0 = v;
         1:       read_enb_1 = v;
         default: read_enb_2 = v;
      endcase
   endtask

   task automatic send_byte(input logic pv, input logic [7:0] d);
      int guard;
      guard = 0;
      pkt_valid = pv;
      data_in = d;
      while (busy === 1'b1 && guard < 100) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (guard >= 100) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy=%0b still high, required 0 within 100 cycles", busy);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      pkt_valid = 1'b0;
      data_in = 8'h00;
      @(posedge clock);
      #1;
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] flip);
      logic [7:0] par;
      exp_q = {};
      par = hdr;
      send_byte(1'b1, hdr);
      exp_q.push_back(hdr);
      foreach (pl[i]) begin
         send_byte(1'b1, pl[i]);
         exp_q.push_back(pl[i]);
         par ^= pl[i];
      end
      send_byte(1'b0, par ^ flip);
      exp_q.push_back(par ^ flip);
      $display("pkt hdr=0x%02h port=%0d payload=%0d parity=0x%02h", hdr, hdr[1:0], pl.size(), par ^ flip);
   endtask

   task automatic drain(input int p);
      int guard;
      guard = 0;
      set_rd(p, 1'b1);
      while (vld(p) && guard < 100) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (guard >= 100) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: port %0d valid still 1, required 0 within 100 cycles", p);
      end
      set_rd(p, 1'b0);
      @(negedge clock);
      #1;
   endtask

   task automatic check_stream(input string name, input int p);
      logic [7:0] act[$];
      case (p)
         0:       act = q0;
         1:       act = q1;
         default: act = q2;
      endcase
      chk({name, "_len"}, act.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act.size(); i++)
         chk($sformatf("%s_b%0d", name, i), act[i], exp_q[i]);
   endtask

   task automatic clear_q();
      q0 = {};
      q1 = {};
      q2 = {};
   endtask

   initial begin
      logic [7:0] par;
      logic [7:0] b;

      resetn = 1'b1;
      pkt_valid = 1'b0;
      data_in = 8'h00;
      read_enb_0 = 1'b0;
      read_enb_1 = 1'b0;
      read_enb_2 = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_valid", {valid_out_0, valid_out_1, valid_out_2}, 0);
      chk("rst_dout", {data_out_0, data_out_1, data_out_2}, 0);
      resetn = 1'b0;
      @(posedge clock);
      #1;

      // Cycle-by-cycle table: packet 0x09 (addr 1) 0x11 0x22, parity 0x3A, then read it out.
      vt[0] = '{1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vt[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vt[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vt[3] = '{1'b0, 8'h3A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
      vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0};
      vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
      vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
      vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0};
      vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0};
      for (int i = 0; i < 9; i++) begin
         pkt_valid = vt[i].pv;
         data_in = vt[i].din;
         read_enb_1 = vt[i].rd1;
         @(posedge clock);
         #1;
         $display("vec %0d pv=%0b din=0x%02h rd1=%0b -> busy=%0b v1=%0b dout1=0x%02h err=%0b",
                  i, vt[i].pv, vt[i].din, vt[i].rd1, busy, valid_out_1, data_out_1, error);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
         chk($sformatf("vec%0d_v1", i), valid_out_1, vt[i].exp_v1);
         chk($sformatf("vec%0d_dout1", i), data_out_1, vt[i].exp_dout1);
         chk($sformatf("vec%0d_err", i), error, vt[i].exp_err);
         chk($sformatf("vec%0d_v0v2", i), {valid_out_0, valid_out_2}, 0);
      end
      read_enb_1 = 1'b0;
      idle();

      // Reset in the middle of a packet, with a previously read byte on data_out_0.
      send_byte(1'b1, 8'h04);
      send_byte(1'b1, 8'h55);
      send_byte(1'b0, 8'h51);
      pkt_valid = 1'b0;
      read_enb_0 = 1'b1;
      @(posedge clock);
      #1;
      read_enb_0 = 1'b0;
      chk("pre_rst_dout0", data_out_0, 8'h04);
      send_byte(1'b1, 8'h3A);
      send_byte(1'b1, 8'h01);
      send_byte(1'b1, 8'h02);
      chk("pre_rst_v2", valid_out_2, 1);
      #2;
      resetn = 1'b1;
      pkt_valid = 1'b0;
      #1;
      chk("midrst_dout0", data_out_0, 0);
      chk("midrst_valid", {valid_out_0, valid_out_1, valid_out_2}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_error", error, 0);
      @(posedge clock);
      #1;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      chk("postrst_valid", {valid_out_0, valid_out_1, valid_out_2}, 0);
      chk("postrst_busy", busy, 0);
      clear_q();

      // Normal 16-byte packet to port 2, read only after loading finishes.
      pl = {};
      for (int i = 0; i < 14; i++) pl.push_back(8'($urandom_range(0, 255)));
      send_pkt(8'h3A, 8'h00);
      chk("norm_full_busy", busy, 1);
      @(posedge clock);
      #1;
      chk("norm_err", error, 0);
      chk("norm_v01", {valid_out_0, valid_out_1}, 0);
      chk("norm_v2", valid_out_2, 1);
      chk("norm_busy_idle", busy, 0);
      drain(2);
      check_stream("norm", 2);

      // Same packet with corrupted parity.
      clear_q();
      send_pkt(8'h3A, 8'h01);
      chk("perr_err_early", error, 0);
      @(posedge clock);
      #1;
      chk("perr_err_set", error, 1);
      drain(2);
      check_stream("perr", 2);
      chk("perr_err_hold", error, 1);
      clear_q();
      send_byte(1'b1, 8'h04);
      chk("perr_err_cleared", error, 0);
      send_byte(1'b1, 8'h55);
      send_byte(1'b0, 8'h51);
      idle();
      drain(0);
      exp_q = {8'h04, 8'h55, 8'h51};
      check_stream("after_perr", 0);

      // Back-pressure: len 18 to port 2, no reads until the FIFO fills.
      clear_q();
      exp_q = {8'h4A};
      par = 8'h4A;
      send_byte(1'b1, 8'h4A);
      for (int i = 0; i < 15; i++) begin
         b = 8'(8'h10 + i);
         send_byte(1'b1, b);
         exp_q.push_back(b);
         par ^= b;
      end
      chk("bp_busy_full", busy, 1);
      chk("bp_v2", valid_out_2, 1);
      pkt_valid = 1'b1;
      data_in = 8'h1F;
      read_enb_2 = 1'b1;
      @(posedge clock);
      #1;
      chk("bp_busy_release", busy, 0);
      for (int i = 15; i < 18; i++) begin
         b = 8'(8'h10 + i);
         send_byte(1'b1, b);
         exp_q.push_back(b);
         par ^= b;
      end
      send_byte(1'b0, par);
      exp_q.push_back(par);
      $display("pkt hdr=0x4a port=2 payload=18 parity=0x%02h (back-pressure)", par);
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("bp_err", error, 0);
      drain(2);
      check_stream("bp", 2);

      // Invalid address: the whole packet is dropped without back-pressure.
      clear_q();
      par = 8'h17;
      chk("drop_busy_hdr", busy, 0);
      send_byte(1'b1, 8'h17);
      for (int i = 0; i < 5; i++) begin
         b = 8'(8'hC1 + i);
         par ^= b;
         chk($sformatf("drop_busy_%0d", i), busy, 0);
         send_byte(1'b1, b);
      end
      chk("drop_busy_par", busy, 0);
      send_byte(1'b0, par);
      $display("pkt hdr=0x17 port=3 payload=5 parity=0x%02h (dropped)", par);
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("drop_valid", {valid_out_0, valid_out_1, valid_out_2}, 0);
      chk("drop_busy_end", busy, 0);
      pl = {8'hA5};
      send_pkt(8'h05, 8'h00);
      idle();
      drain(1);
      check_stream("after_drop", 1);

      // Second header to port 0 while port 0 still holds a packet.
      clear_q();
      send_byte(1'b1, 8'h04);
      send_byte(1'b1, 8'h55);
      send_byte(1'b0, 8'h51);
      send_byte(1'b1, 8'h08);
      chk("b2b_wait_busy", busy, 1);
      pkt_valid = 1'b1;
      data_in = 8'h66;
      @(posedge clock);
      #1;
      chk("b2b_wait_busy2", busy, 1);
      chk("b2b_v0", valid_out_0, 1);
      read_enb_0 = 1'b1;
      send_byte(1'b1, 8'h66);
      send_byte(1'b1, 8'h77);
      send_byte(1'b0, 8'h19);
      $display("pkt hdr=0x08 port=0 payload=2 parity=0x19 (back-to-back)");
      idle();
      chk("b2b_err", error, 0);
      drain(0);
      exp_q = {8'h04, 8'h55, 8'h51, 8'h08, 8'h66, 8'h77, 8'h19};
      check_stream("b2b", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
